// File: rtl/ram_loader.sv
// ram_loader: serial boot loader in front of the CPU RAM write port.
//
// Consumes a byte stream: a 16-bit big-endian word count N, then N
// big-endian 16-bit data words, then an 8-bit checksum (sum of the data
// bytes modulo 256). Each word is written to RAM addresses 0..N-1. The CPU
// is held in reset while a load is in progress.
//
// Ports
//   clk       system clock, all logic on posedge
//   reset     synchronous, active-high reset
//   start     one-cycle pulse that begins a load (ignored while busy)
//   rx_data   received byte, valid when rx_valid=1
//   rx_valid  one-cycle strobe per received byte
//   wr_addr   RAM write address
//   wr_data   RAM write data
//   wr_en     RAM write enable, one-cycle pulse per word
//   busy      load in progress
//   done      sticky, load succeeded
//   err       sticky, load failed (length, checksum or timeout)
//   cpu_hold  keeps the CPU in reset, equals busy
//   words     words written in the current or last load
module ram_loader #(
  parameter int DEPTH   = 4092,
  parameter int TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [11:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        wr_en,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_hold,
  output logic [11:0] words
);

  // Idle-time counter only needs to reach TIMEOUT; keep at least one bit
  // so the design still elaborates with the timeout disabled.
  localparam int             TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0]  TMAX    = TW'(TIMEOUT);
  localparam logic [15:0]    DEPTH_W = 16'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DAT_HI,
    S_DAT_LO,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [7:0]    hi_q, hi_d;
  logic [7:0]    csum_q, csum_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          wr_en_d;
  logic [11:0]   wr_addr_d;
  logic [15:0]   wr_data_d;
  logic [11:0]   words_d;
  logic          busy_d, done_d, err_d;

  logic [15:0]   len_full;
  logic [11:0]   words_inc;
  logic          idle_like;

  assign len_full  = {len_q[15:8], rx_data};
  assign words_inc = words + 12'd1;
  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
  assign cpu_hold  = busy;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    state_d   = state_q;
    len_d     = len_q;
    hi_d      = hi_q;
    csum_d    = csum_q;
    tcnt_d    = tcnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    words_d   = words;

    if (idle_like) begin
      // A byte arriving together with start is dropped: only start matters here.
      if (start) begin
        state_d   = S_LEN_HI;
        csum_d    = 8'h00;
        tcnt_d    = '0;
        wr_addr_d = 12'd0;
        words_d   = 12'd0;
      end
    end else if (rx_valid) begin
      tcnt_d = '0;
      case (state_q)
        S_LEN_HI: begin
          len_d[15:8] = rx_data;
          state_d     = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_d = len_full;
          if (len_full == 16'd0 || len_full > DEPTH_W) state_d = S_ERR;
          else                                         state_d = S_DAT_HI;
        end
        S_DAT_HI: begin
          hi_d    = rx_data;
          csum_d  = csum_q + rx_data;
          state_d = S_DAT_LO;
        end
        S_DAT_LO: begin
          // The word count doubles as the write address: word i lands at i.
          wr_en_d   = 1'b1;
          wr_addr_d = words;
          wr_data_d = {hi_q, rx_data};
          words_d   = words_inc;
          csum_d    = csum_q + rx_data;
          if ({4'd0, words_inc} == len_q) state_d = S_CSUM;
          else                            state_d = S_DAT_HI;
        end
        S_CSUM: begin
          if (rx_data == csum_q) state_d = S_DONE;
          else                   state_d = S_ERR;
        end
        default: state_d = state_q;
      endcase
    end else if (TIMEOUT != 0) begin
      // Counter reaching TIMEOUT on an earlier edge aborts on this one.
      if (tcnt_q == TMAX) state_d = S_ERR;
      else                tcnt_d  = tcnt_q + 1'b1;
    end

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERR);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= 16'd0;
      hi_q    <= 8'h00;
      csum_q  <= 8'h00;
      tcnt_q  <= '0;
      wr_en   <= 1'b0;
      wr_addr <= 12'd0;
      wr_data <= 16'd0;
      words   <= 12'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      hi_q    <= hi_d;
      csum_q  <= csum_d;
      tcnt_q  <= tcnt_d;
      wr_en   <= wr_en_d;
      wr_addr <= wr_addr_d;
      wr_data <= wr_data_d;
      words   <= words_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader (TIMEOUT shortened to 16 cycles).
module tb_ram_loader;

  logic        clk = 1'b0;
  logic        reset, start, rx_valid;
  logic [7:0]  rx_data;
  logic [11:0] wr_addr, words;
  logic [15:0] wr_data;
  logic        wr_en, busy, done, err, cpu_hold;

  int checks = 0;
  int errors = 0;

  logic [11:0] wq_addr[$];
  logic [15:0] wq_data[$];

  always #5 clk = ~clk;

  ram_loader #(.DEPTH(4092), .TIMEOUT(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cpu_hold (cpu_hold),
    .words    (words)
  );

  // Log every RAM write in the middle of its enable cycle.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
    end
  end

  typedef struct {
    logic        rst, st, rv;
    logic [7:0]  rd;
    logic        wen;
    logic [11:0] addr;
    logic [15:0] data;
    logic        bsy, dn, er;
    logic [11:0] wrds;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic s, input logic v, input logic [7:0] d);
    reset = r; start = s; rx_valid = v; rx_data = d;
    tick();
    reset = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
  endtask

  task automatic send(input logic [7:0] b);
    drive(1'b0, 1'b0, 1'b1, b);
  endtask

  // {wr_en, wr_addr, wr_data, busy, done, err, cpu_hold, words}
  function automatic logic [63:0] snap();
    return 64'({wr_en, wr_addr, wr_data, busy, done, err, cpu_hold, words});
  endfunction

  function automatic logic [63:0] expv(input vec_t v);
    return 64'({v.wen, v.addr, v.data, v.bsy, v.dn, v.er, v.bsy, v.wrds});
  endfunction

  vec_t vecs[17];

  initial begin
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

    // Nominal load (checksum 12+34+AB+CD = 0x1BE -> 0xBE), start+byte
    // collision, zero length, then length 4093.
    //            rst st  rv  rd     wen addr    data       bsy dn  er  words
    vecs[0]  = '{1'b1,1'b0,1'b0,8'h00, 1'b0,12'd0,16'h0000, 1'b0,1'b0,1'b0,12'd0};
    vecs[1]  = '{1'b0,1'b1,1'b0,8'h00, 1'b0,12'd0,16'h0000, 1'b1,1'b0,1'b0,12'd0};
    vecs[2]  = '{1'b0,1'b0,1'b1,8'h00, 1'b0,12'd0,16'h0000, 1'b1,1'b0,1'b0,12'd0};
    vecs[3]  = '{1'b0,1'b0,1'b1,8'h02, 1'b0,12'd0,16'h0000, 1'b1,1'b0,1'b0,12'd0};
    vecs[4]  = '{1'b0,1'b0,1'b1,8'h12, 1'b0,12'd0,16'h0000, 1'b1,1'b0,1'b0,12'd0};
    vecs[5]  = '{1'b0,1'b0,1'b1,8'h34, 1'b1,12'd0,16'h1234, 1'b1,1'b0,1'b0,12'd1};
    vecs[6]  = '{1'b0,1'b0,1'b1,8'hAB, 1'b0,12'd0,16'h1234, 1'b1,1'b0,1'b0,12'd1};
    vecs[7]  = '{1'b0,1'b0,1'b1,8'hCD, 1'b1,12'd1,16'hABCD, 1'b1,1'b0,1'b0,12'd2};
    vecs[8]  = '{1'b0,1'b0,1'b1,8'hBE, 1'b0,12'd1,16'hABCD, 1'b0,1'b1,1'b0,12'd2};
    vecs[9]  = '{1'b0,1'b0,1'b1,8'h55, 1'b0,12'd1,16'hABCD, 1'b0,1'b1,1'b0,12'd2};
    vecs[10] = '{1'b0,1'b1,1'b1,8'h00, 1'b0,12'd0,16'hABCD, 1'b1,1'b0,1'b0,12'd0};
    vecs[11] = '{1'b0,1'b0,1'b1,8'h00, 1'b0,12'd0,16'hABCD, 1'b1,1'b0,1'b0,12'd0};
    vecs[12] = '{1'b0,1'b0,1'b1,8'h00, 1'b0,12'd0,16'hABCD, 1'b0,1'b0,1'b1,12'd0};
    vecs[13] = '{1'b0,1'b1,1'b0,8'h00, 1'b0,12'd0,16'hABCD, 1'b1,1'b0,1'b0,12'd0};
    vecs[14] = '{1'b0,1'b0,1'b1,8'h0F, 1'b0,12'd0,16'hABCD, 1'b1,1'b0,1'b0,12'd0};
    vecs[15] = '{1'b0,1'b0,1'b1,8'hFD, 1'b0,12'd0,16'hABCD, 1'b0,1'b0,1'b1,12'd0};
    vecs[16] = '{1'b0,1'b0,1'b1,8'hFC, 1'b0,12'd0,16'hABCD, 1'b0,1'b0,1'b1,12'd0};

    tick();
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].rst, vecs[i].st, vecs[i].rv, vecs[i].rd);
      check($sformatf("vec%0d", i), snap(), expv(vecs[i]));
    end
    check("table_write_count", 64'(wq_addr.size()), 64'd2);

    // Bad checksum: both words still written, then err.
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    wq_addr.delete(); wq_data.delete();
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    send(8'h00); send(8'h02); send(8'h12); send(8'h34);
    send(8'hAB); send(8'hCD); send(8'hBF);
    check("badcs_writes", 64'(wq_addr.size()), 64'd2);
    check("badcs_w0", 64'({wq_addr[0], wq_data[0]}), 64'({12'd0, 16'h1234}));
    check("badcs_w1", 64'({wq_addr[1], wq_data[1]}), 64'({12'd1, 16'hABCD}));
    check("badcs_flags", 64'({busy, done, err, cpu_hold}), 64'(4'b0010));

    // Maximum length, bytes every cycle.
    begin
      logic [7:0]  sum;
      logic [11:0] iv;
      logic [15:0] w;
      int          bad;
      sum = 8'h00;
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      wq_addr.delete(); wq_data.delete();
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      send(8'h0F); send(8'hFC);
      for (int i = 0; i < 4092; i++) begin
        iv = 12'(i);
        w  = {iv[7:0] ^ 8'h3C, iv[11:4]};
        send(w[15:8]);
        send(w[7:0]);
        sum = sum + w[15:8] + w[7:0];
      end
      send(sum);
      check("max_flags", 64'({busy, done, err}), 64'(3'b010));
      check("max_words", 64'(words), 64'h0FFC);
      check("max_writes", 64'(wq_addr.size()), 64'd4092);
      bad = 0;
      for (int i = 0; i < wq_addr.size(); i++) begin
        iv = 12'(i);
        w  = {iv[7:0] ^ 8'h3C, iv[11:4]};
        if (wq_addr[i] !== iv || wq_data[i] !== w) bad++;
      end
      check("max_order", 64'(bad), 64'd0);
    end

    // Timeout: silence after 00 03 11 gives err exactly 17 edges later.
    begin
      int early;
      early = 0;
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      wq_addr.delete(); wq_data.delete();
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      send(8'h00); send(8'h03); send(8'h11);
      for (int j = 1; j <= 16; j++) begin
        tick();
        if (err !== 1'b0 || busy !== 1'b1) early++;
      end
      check("to_early", 64'(early), 64'd0);
      tick();
      check("to_flags", 64'({busy, done, err, cpu_hold}), 64'(4'b0010));
      check("to_writes", 64'(wq_addr.size()), 64'd0);
    end

    // Start while busy is ignored; reset after first word aborts; restart works.
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    wq_addr.delete(); wq_data.delete();
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    send(8'h00); send(8'h03); send(8'h11); send(8'h22);
    check("rs_first_write", 64'({wr_en, wr_addr, wr_data}), 64'({1'b1, 12'd0, 16'h1122}));
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    check("rs_start_ignored", 64'({busy, words}), 64'({1'b1, 12'd1}));
    send(8'h33);
    drive(1'b1, 1'b0, 1'b1, 8'h44);
    check("rs_reset", 64'({wr_en, busy, cpu_hold, done, err, words}), 64'({5'b00000, 12'd0}));
    check("rs_reset_writes", 64'(wq_addr.size()), 64'd1);
    wq_addr.delete(); wq_data.delete();
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    check("rs_restart_busy", 64'(busy), 64'd1);
    send(8'h00); send(8'h01); send(8'hAA); send(8'h55); send(8'hFF);
    check("rs_done", 64'({busy, done, err, words}), 64'({3'b010, 12'd1}));
    check("rs_write", 64'({wq_addr.size() == 1, wq_addr[0], wq_data[0]}),
          64'({1'b1, 12'd0, 16'hAA55}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
